// File: rtl/serial_flop_tx_pkg.sv
// Shared definitions for the serial flop link: FSM encodings and counter sizing.
// The receive-side block imports this package so both ends decode the same constants.
package serial_flop_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } state_e;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_flop_tx_half_period_counter.sv
// Divide-by-DIV counter; tc_o pulses on the last count of each enabled half-period.
// Reusable for any divided lab clock.
module half_period_counter
  import serial_flop_tx_pkg::*;
#(
  parameter int unsigned DIV = 4
) (
  input  logic Clk,
  input  logic Resetn,
  input  logic clear_i,
  input  logic enable_i,
  output logic tc_o
);

  localparam int unsigned   CW   = cnt_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tc_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/serial_flop_tx.sv
// Parallel-in, serial-out transmitter producing a registered SClk/SData pair, MSB first.
// SData only changes as SClk falls, so each SClk rise sees a half-period of setup and hold.
module serial_flop_tx
  import serial_flop_tx_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             Start,
  input  logic [WIDTH-1:0] Data,
  output logic             Busy,
  output logic             Done,
  output logic             SClk,
  output logic             SData,
  output logic             SFrame
);

  localparam int unsigned    BCW      = cnt_width(WIDTH);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, shreg_shift;
  logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             sclk_q, sclk_d, sdata_q, sdata_d, sframe_q, sframe_d;
  logic             half_tc, last_bit;

  half_period_counter #(.DIV(DIV)) u_half_period_counter (
    .Clk      (Clk),
    .Resetn   (Resetn),
    .clear_i  (state_q == ST_IDLE),
    .enable_i (state_q != ST_IDLE),
    .tc_o     (half_tc)
  );

  assign last_bit    = (bit_cnt_q == BIT_LAST);
  assign shreg_shift = shreg_q << 1;

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (Start)   state_d = ST_LOW;
      ST_LOW:  if (half_tc) state_d = ST_HIGH;
      ST_HIGH: if (half_tc) state_d = last_bit ? ST_IDLE : ST_LOW;
      default:              state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath, decoded from the current state.
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sclk_d    = sclk_q;
    sdata_d   = sdata_q;
    sframe_d  = sframe_q;
    unique case (state_q)
      ST_IDLE: begin
        sclk_d   = 1'b0;
        sdata_d  = 1'b0;
        sframe_d = 1'b0;
        busy_d   = 1'b0;
        if (Start) begin
          shreg_d   = Data;
          sdata_d   = Data[WIDTH-1];
          sframe_d  = 1'b1;
          busy_d    = 1'b1;
          bit_cnt_d = '0;
        end
      end
      ST_LOW: if (half_tc) sclk_d = 1'b1;
      ST_HIGH: begin
        if (half_tc) begin
          sclk_d = 1'b0;
          if (last_bit) begin
            sdata_d  = 1'b0;
            sframe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_shift;
            sdata_d   = shreg_shift[WIDTH-1];
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sclk_q    <= 1'b0;
      sdata_q   <= 1'b0;
      sframe_q  <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sclk_q    <= sclk_d;
      sdata_q   <= sdata_d;
      sframe_q  <= sframe_d;
    end
  end

  assign Busy   = busy_q;
  assign Done   = done_q;
  assign SClk   = sclk_q;
  assign SData  = sdata_q;
  assign SFrame = sframe_q;

endmodule

// File: tb/tb_serial_flop_tx.sv
// Directed bench for serial_flop_tx: table of frames checked by a loopback receiver,
// plus hand-written reset, abort and DIV=1/WIDTH=1 sequences.
module tb_serial_flop_tx;

  localparam int W     = 8;
  localparam int D     = 4;
  localparam int FRAME = 2 * D * W;

  logic       clk = 1'b0;
  logic       resetn;
  logic       start, busy, done, sclk, sdata, sframe;
  logic [7:0] data;
  logic       start1, data1, busy1, done1, sclk1, sdata1, sframe1;
  logic [7:0] rx;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_flop_tx #(.WIDTH(W), .DIV(D)) dut (
    .Clk(clk), .Resetn(resetn), .Start(start), .Data(data),
    .Busy(busy), .Done(done), .SClk(sclk), .SData(sdata), .SFrame(sframe)
  );

  serial_flop_tx #(.WIDTH(1), .DIV(1)) dut1 (
    .Clk(clk), .Resetn(resetn), .Start(start1), .Data(data1),
    .Busy(busy1), .Done(done1), .SClk(sclk1), .SData(sdata1), .SFrame(sframe1)
  );

  // Receive side: plain rising-edge shift register clocked by SClk.
  always @(posedge sclk) rx <= {rx[6:0], sdata};

  typedef struct {
    logic [7:0] data;      // word launched
    int         ign_at;    // cycle index of an extra Start pulse during the frame (-1: none)
    logic [7:0] ign_data;  // Data driven with that ignored pulse
    bit         chain;     // relaunch in the Done cycle (back-to-back)
    logic [7:0] exp;       // word the receiver must hold afterwards
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
  task automatic launch(input logic [7:0] d);
    start = 1'b1;
    data  = d;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    data  = ~d;
    check("accept_busy", busy, 1);
    check("accept_sframe", sframe, 1);
    check("accept_sdata", sdata, d[7]);
    check("accept_sclk", sclk, 0);
  endtask

  // Samples one negedge per cycle from the accept cycle (n=0) until Done is seen.
  task automatic watch(input vec_t v);
    int   rises = 0, bad_t = 0, bad_bit = 0, bad_stable = 0;
    int   busy_n = 0, done_at = -1, bad_frame = 0;
    logic prev_sclk = 1'b0;
    logic [7:0] e = v.exp;
    for (int n = 0; n < FRAME + 20; n++) begin
      if (sframe !== busy) bad_frame++;
      if (busy === 1'b1) busy_n++;
      if (sclk === 1'b1 && prev_sclk === 1'b0) begin
        if (rises < W) begin
          if (n != D + 2 * D * rises) bad_t++;
          if (sdata !== e[W-1-rises]) bad_bit++;
        end
        rises++;
      end
      if (sclk === 1'b1 && rises >= 1 && rises <= W && sdata !== e[W-rises]) bad_stable++;
      prev_sclk = sclk;
      if (n == v.ign_at) begin start = 1'b1; data = v.ign_data; end
      if (n == v.ign_at + 1) begin start = 1'b0; data = ~v.data; end
      if (done === 1'b1) begin
        done_at = n;
        break;
      end
      @(negedge clk);
    end
    check("done_time", done_at, FRAME);
    check("rise_count", rises, W);
    check("rise_times", bad_t, 0);
    check("bit_at_rise", bad_bit, 0);
    check("sdata_stable_high", bad_stable, 0);
    check("busy_len", busy_n, FRAME);
    check("sframe_eq_busy", bad_frame, 0);
    check("done_cycle_sclk", sclk, 0);
    check("rx_word", rx, v.exp);
    if (!v.chain) begin
      @(negedge clk);
      check("done_clear", done, 0);
      check("idle_busy", busy, 0);
      @(negedge clk);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] c_sclk, c_busy, c_done, c_sdata;
    int noisy;
    vecs[0] = '{8'hA5, -1, 8'h00, 1'b0, 8'hA5};
    vecs[1] = '{8'h3C, -1, 8'h00, 1'b0, 8'h3C};
    vecs[2] = '{8'h00, -1, 8'h00, 1'b0, 8'h00};
    vecs[3] = '{8'hFF, -1, 8'h00, 1'b0, 8'hFF};
    vecs[4] = '{8'h81, -1, 8'h00, 1'b0, 8'h81};
    vecs[5] = '{8'hF0, 10, 8'h0F, 1'b0, 8'hF0};
    vecs[6] = '{8'hC3, -1, 8'h00, 1'b1, 8'hC3};
    vecs[7] = '{8'h55, -1, 8'h00, 1'b0, 8'h55};

    // Reset with Start and Data active.
    resetn = 1'b0; start = 1'b1; data = 8'hFF; start1 = 1'b0; data1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sclk", sclk, 0);
    check("rst_sdata", sdata, 0);
    check("rst_sframe", sframe, 0);
    start = 1'b0;
    resetn = 1'b1;
    noisy = 0;
    repeat (20) begin
      @(negedge clk);
      if ({busy, done, sclk, sdata, sframe} !== 5'b0) noisy++;
    end
    check("idle_quiet", noisy, 0);

    foreach (vecs[i]) begin
      launch(vecs[i].data);
      watch(vecs[i]);
    end

    // Abort mid-frame: reset is asynchronous and suppresses Done.
    launch(8'hA5);
    repeat (30) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("abort_outputs", {busy, done, sclk, sdata, sframe}, 5'b0);
    noisy = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) noisy++;
    end
    resetn = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done !== 1'b0) noisy++;
    end
    check("abort_no_done", noisy, 0);
    launch(8'h5A);
    watch('{8'h5A, -1, 8'h00, 1'b0, 8'h5A});

    // DIV=1, WIDTH=1 corner, samples at n=0..3 after the accept edge.
    c_sclk = 4'b0010; c_busy = 4'b0011; c_done = 4'b0100; c_sdata = 4'b0011;
    start1 = 1'b1; data1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start1 = 1'b0; data1 = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check($sformatf("c1_sclk_%0d", n), sclk1, c_sclk[n]);
      check($sformatf("c1_busy_%0d", n), busy1, c_busy[n]);
      check($sformatf("c1_done_%0d", n), done1, c_done[n]);
      check($sformatf("c1_sdata_%0d", n), sdata1, c_sdata[n]);
      check($sformatf("c1_sframe_%0d", n), sframe1, c_busy[n]);
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
